adc_capture: RTL

Bus-responder sample buffer on the 6502 data bus at page 4x (selected by `CPU_AB[15:12] == 4'h4`) that replaces the raw `adc` read path. Captures 8-bit ADC samples on a strobe, decimates them, and stores them in an internal FIFO. Firmware controls the block and drains the FIFO through four byte registers. Read data is registered so it lines up with the one-cycle-late registered data mux on the CPU side.

---
 rtl/adc_capture.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/adc_capture.sv
// adc_capture: decimating ADC sample FIFO behind four CPU byte registers (page 4x).
// Define ADC_CAPTURE_TRIG_EN to add the TRIG level register (rs=3 write) and the WAIT state.
module adc_capture #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] adc,
    input  logic       adc_stb,
    output logic       irq,
    output logic [1:0] dbg_state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_LAST = (DEPTH_LOG2 + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            decim_q, decim_d;
    logic [7:0]            dcnt_q, dcnt_d;
    logic [7:0]            dout_q, dout_d;
    logic                  cont_q, cont_d;
    logic                  irqen_q, irqen_d;
    logic                  ovf_q, ovf_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            cnt_lo;

    logic wr_ctrl, flush, arm, empty, full, pop;
    logic in_window, take, push, drop, crossing, busy, done;

`ifdef ADC_CAPTURE_TRIG_EN
    localparam state_t ARM_STATE = S_WAIT;
    logic [7:0] trig_q, trig_d, prev_q, prev_d;

    // prev tracks every strobed sample so a crossing is judged against the true previous value
    assign crossing = (prev_q < trig_q) & (adc >= trig_q);

    always_comb begin
        trig_d = trig_q;
        prev_d = prev_q;
        if (cs & we & (rs == 2'd3)) trig_d = din;
        if (adc_stb) prev_d = adc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q <= 8'h80;
            prev_q <= 8'h00;
        end else begin
            trig_q <= trig_d;
            prev_q <= prev_d;
        end
    end
`else
    localparam state_t ARM_STATE = S_CAPTURE;
    assign crossing = 1'b0;
`endif

    assign wr_ctrl   = cs & we & (rs == 2'd0);
    assign flush     = wr_ctrl & din[7];
    assign arm       = wr_ctrl & din[0] & ~din[7] & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_FULL);
    assign pop       = cs & ~we & (rs == 2'd2) & ~empty;
    assign in_window = (state_q == S_CAPTURE) | ((state_q == S_WAIT) & crossing);
    // take: a strobe that survives decimation while capturing (or is the trigger sample)
    assign take      = adc_stb & (dcnt_q == 8'd0) & in_window & ~flush;
    assign push      = take & ~full;
    assign drop      = take & full;
    assign cnt_lo    = 8'(cnt_q);
    assign dout      = dout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            decim_q  <= 8'h00;
            dcnt_q   <= 8'h00;
            dout_q   <= 8'h00;
            cont_q   <= 1'b0;
            irqen_q  <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            decim_q  <= decim_d;
            dcnt_q   <= dcnt_d;
            dout_q   <= dout_d;
            cont_q   <= cont_d;
            irqen_q  <= irqen_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= adc;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (arm) begin
            state_d = ARM_STATE;
        end else if (take) begin
            if (~cont_q & (drop | (~pop & (cnt_q == CNT_LAST)))) state_d = S_DONE;
            else state_d = S_CAPTURE;
        end
    end

    always_comb begin
        busy      = (state_q == S_CAPTURE) | (state_q == S_WAIT);
        done      = (state_q == S_DONE);
        irq       = irqen_q & (done | ovf_q);
        dbg_state = state_q;
    end

    always_comb begin
        decim_d  = decim_q;
        dcnt_d   = dcnt_q;
        dout_d   = dout_q;
        cont_d   = cont_q;
        irqen_d  = irqen_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
        if (cs & we & (rs == 2'd1)) decim_d = din;
        if (wr_ctrl) begin
            cont_d  = din[1];
            irqen_d = din[6];
        end
        if (adc_stb & busy) dcnt_d = (dcnt_q == 8'd0) ? decim_q : dcnt_q - 8'd1;
        if (arm) dcnt_d = 8'd0;
        if (drop & cont_q) ovf_d = 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        if (flush) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            dcnt_d   = 8'd0;
        end
        if (cs & ~we) begin
            unique case (rs)
                2'd0:    dout_d = {1'b0, irqen_q, 1'b0, done, ovf_q, empty, full, busy};
                2'd1:    dout_d = decim_q;
                2'd2:    dout_d = empty ? 8'h00 : mem_q[rd_ptr_q];
                default: dout_d = cnt_lo;
            endcase
        end
    end
endmodule
